// File: rtl/fifo_ctrl_if.sv
// Request and status bundle between the push-button front end and the FIFO pointer controller.
interface fifo_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  write;
  logic                  read;
  logic                  wren;
  logic [ADDR_WIDTH-1:0] wraddress;
  logic [ADDR_WIDTH-1:0] rdaddress;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;

  modport master (
    output write, read,
    input  wren, wraddress, rdaddress, count, empty, full
  );

  modport slave (
    input  write, read,
    output wren, wraddress, rdaddress, count, empty, full
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller that turns a 2**ADDR_WIDTH-entry dual-port RAM into a FIFO.
// Push/pop requests are asynchronous levels; each rising edge yields one request pulse.
module fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic       clock,
  input  logic       reset,
  fifo_ctrl_if.slave bus
);
  localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W   = ADDR_WIDTH + 1;
  localparam int unsigned SYNC_W  = 3;

  // Per request: bit0 = s1, bit1 = s2, bit2 = previous s2
  logic [SYNC_W-1:0]     wr_sync;
  logic [SYNC_W-1:0]     rd_sync;
  logic                  wr_pulse;
  logic                  rd_pulse;
  logic                  wr_acc;
  logic                  rd_acc;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_next;
  logic                  empty_q;
  logic                  full_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_sync <= '0;
      rd_sync <= '0;
    end else begin
      wr_sync <= {wr_sync[1:0], bus.write};
      rd_sync <= {rd_sync[1:0], bus.read};
    end
  end

  assign wr_pulse = wr_sync[1] & ~wr_sync[2];
  assign rd_pulse = rd_sync[1] & ~rd_sync[2];
  assign wr_acc   = wr_pulse & ~full_q;
  assign rd_acc   = rd_pulse & ~empty_q;

  // Occupancy moves only when exactly one side is accepted
  always_comb begin
    count_next = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  // Flags are registered from the next count so they switch cleanly with count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      count_q <= count_next;
      empty_q <= (count_next == CNT_W'(0));
      full_q  <= (count_next == CNT_W'(DEPTH));
    end
  end

  assign bus.wren      = wr_acc;
  assign bus.wraddress = wr_ptr;
  assign bus.rdaddress = rd_ptr;
  assign bus.count     = count_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl against a queue-based FIFO occupancy model.
module tb_fifo_ctrl;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  // Reference model: queue of slot addresses, plus lifetime push/pop totals
  int   model_q[$];
  int   wr_total;
  int   rd_total;

  fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clock);
    bus.write = 1'b0;
    bus.read  = 1'b0;
    reset     = 1'b1;
    model_q.delete();
    wr_total = 0;
    rd_total = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // One press of write and/or read held across the pulse window, then released
  task automatic press(input bit w, input bit r, input string tag);
    bit exp_w;
    bit exp_r;
    int exp_cnt;
    @(negedge clock);
    bus.write = w;
    bus.read  = r;
    @(posedge clock); #1;
    checks++;
    if (bus.wren !== 1'b0) begin
      errors++; $display("FAIL %s early_wren: got %0b expected 0", tag, bus.wren);
    end
    exp_w = w && (model_q.size() < DEPTH);
    exp_r = r && (model_q.size() > 0);
    @(posedge clock); #1;
    checks++;
    if (bus.wren !== exp_w) begin
      errors++; $display("FAIL %s wren: got %0b expected %0b", tag, bus.wren, exp_w);
    end
    if (exp_w) begin
      checks++;
      if (int'(bus.wraddress) !== wr_total % DEPTH) begin
        errors++; $display("FAIL %s wraddress_at_wren: got %0d expected %0d", tag, bus.wraddress, wr_total % DEPTH);
      end
      model_q.push_back(wr_total % DEPTH);
      wr_total++;
    end
    if (exp_r) begin
      void'(model_q.pop_front());
      rd_total++;
    end
    @(posedge clock); #1;
    exp_cnt = model_q.size();
    checks++;
    if (int'(bus.wraddress) !== wr_total % DEPTH || int'(bus.rdaddress) !== rd_total % DEPTH) begin
      errors++; $display("FAIL %s pointers: got wr=%0d rd=%0d expected wr=%0d rd=%0d", tag,
                         bus.wraddress, bus.rdaddress, wr_total % DEPTH, rd_total % DEPTH);
    end
    checks++;
    if (int'(bus.count) !== exp_cnt || bus.empty !== (exp_cnt == 0) || bus.full !== (exp_cnt == DEPTH)) begin
      errors++; $display("FAIL %s count_flags: got count=%0d empty=%0b full=%0b expected count=%0d empty=%0b full=%0b", tag,
                         bus.count, bus.empty, bus.full, exp_cnt, exp_cnt == 0, exp_cnt == DEPTH);
    end
    checks++;
    if (((int'(bus.wraddress) - int'(bus.rdaddress) + DEPTH) % DEPTH) !== (int'(bus.count) % DEPTH) || int'(bus.count) > DEPTH) begin
      errors++; $display("FAIL %s invariant: got wr=%0d rd=%0d count=%0d expected difference matching count", tag,
                         bus.wraddress, bus.rdaddress, bus.count);
    end
    @(negedge clock);
    bus.write = 1'b0;
    bus.read  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.wren !== 1'b0 || int'(bus.count) !== exp_cnt) begin
      errors++; $display("FAIL %s after_release: got wren=%0b count=%0d expected wren=0 count=%0d", tag, bus.wren, bus.count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.count !== 6'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.wraddress !== 5'd0 || bus.rdaddress !== 5'd0 || bus.wren !== 1'b0) begin
      errors++; $display("FAIL reset_values: got count=%0d empty=%0b full=%0b wr=%0d rd=%0d wren=%0b expected 0 1 0 0 0 0",
                         bus.count, bus.empty, bus.full, bus.wraddress, bus.rdaddress, bus.wren);
    end
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, "reset_fill");
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.count !== 6'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.wraddress !== 5'd0 || bus.rdaddress !== 5'd0 || bus.wren !== 1'b0) begin
      errors++; $display("FAIL async_reset: got count=%0d empty=%0b full=%0b wr=%0d rd=%0d wren=%0b expected 0 1 0 0 0 0",
                         bus.count, bus.empty, bus.full, bus.wraddress, bus.rdaddress, bus.wren);
    end
    model_q.delete();
    wr_total = 0;
    rd_total = 0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single_push();
    int n_wren;
    int first;
    int addr_at;
    do_reset();
    n_wren  = 0;
    first   = -1;
    addr_at = -1;
    @(negedge clock);
    bus.write = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (bus.wren === 1'b1) begin
        n_wren++;
        first   = i;
        addr_at = int'(bus.wraddress);
      end
    end
    checks++;
    if (n_wren !== 1 || first !== 1 || addr_at !== 0) begin
      errors++; $display("FAIL single_push_pulse: got n=%0d at=%0d addr=%0d expected n=1 at=1 addr=0", n_wren, first, addr_at);
    end
    checks++;
    if (bus.wraddress !== 5'd1 || bus.count !== 6'd1 || bus.empty !== 1'b0) begin
      errors++; $display("FAIL single_push_state: got wr=%0d count=%0d empty=%0b expected 1 1 0", bus.wraddress, bus.count, bus.empty);
    end
    model_q.push_back(0);
    wr_total = 1;
    @(negedge clock);
    bus.write = 1'b0;
    repeat (3) @(negedge clock);
    press(1'b1, 1'b0, "second_push");
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) press(1'b1, 1'b0, "fill");
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 6'd32 || bus.wraddress !== 5'd0) begin
      errors++; $display("FAIL fill_end: got full=%0b count=%0d wr=%0d expected 1 32 0", bus.full, bus.count, bus.wraddress);
    end
    for (int i = 0; i < DEPTH + 1; i++) press(1'b0, 1'b1, "drain");
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 6'd0 || bus.rdaddress !== 5'd0) begin
      errors++; $display("FAIL drain_end: got empty=%0b count=%0d rd=%0d expected 1 0 0", bus.empty, bus.count, bus.rdaddress);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, "sim_pre3");
    press(1'b1, 1'b1, "sim_mid");
    do_reset();
    press(1'b1, 1'b1, "sim_empty");
    do_reset();
    for (int i = 0; i < DEPTH; i++) press(1'b1, 1'b0, "sim_prefull");
    press(1'b1, 1'b1, "sim_full");
  endtask

  task automatic test_random_wrap();
    bit w;
    bit r;
    for (int i = 0; i < 100; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (!w && !r) w = 1'b1;
      press(w, r, "random");
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    bus.write = 1'b0;
    bus.read  = 1'b0;
    wr_total  = 0;
    rd_total  = 0;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_simultaneous();
    test_random_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller that turns the 32x4 dual-port RAM into a 32-entry FIFO. It sits directly upstream of ram32x4 and replaces the free-running read-address counter. It drives the RAM's wraddress, rdaddress and wren from two push-button level inputs, and tracks occupancy and full/empty for the HEX/LEDR display logic. Write data goes from the switches straight to the RAM and does not pass through this block.

## Interface
- ADDR_WIDTH, 5, RAM address width; FIFO depth = 2**ADDR_WIDTH (32)
- clock  in  1  system clock (CLOCK_50); all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- write  in  1  asynchronous level request (active-high, e.g. ~KEY[3]); each rising edge is one push
- read  in  1  asynchronous level request (active-high, e.g. ~KEY[2]); each rising edge is one pop
- wren  out  1  write enable to RAM; combinational, high only in a cycle where a push is accepted
- wraddress  out  ADDR_WIDTH  write pointer; registered; RAM address for the accepted push
- rdaddress  out  ADDR_WIDTH  read pointer; registered; address of the current head entry
- count  out  ADDR_WIDTH+1  occupancy, 0..32; registered
- empty  out  1  count == 0
- full  out  1  count == 32

## Operation
- Each of write and read passes through a 2-flop synchronizer (s1, s2) and then a previous-value flop (p). The request pulse is s2 & ~p.
- All synchronizer and previous-value flops reset to 0. A request already held high when reset releases therefore produces exactly one pulse.
- Holding an input high produces exactly one pulse, regardless of duration. The next pulse requires the input to go low for at least one sampled cycle and then high again.
- Push accept: wr_acc = wr_pulse & ~full.
- Pop accept: rd_acc = rd_pulse & ~empty.
- Requests are never queued. A rejected pulse is dropped.
- wren = wr_acc. At the accepting edge, the RAM captures wraddress, the data and wren; at the same edge, wraddress increments.
- rd_acc increments rdaddress. The popped head is discarded and the next entry becomes the head.
- Pointers wrap modulo 32 (31 -> 0) with no special handling.
- count is updated per accepting edge:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither are accepted
- Simultaneous pulses:
  - Neither full nor empty: both accepted; both pointers advance; count unchanged.
  - Empty: push accepted, pop rejected; count goes 0 -> 1.
  - Full: pop accepted, push rejected; count goes 32 -> 31.
- Invariant: wraddress - rdaddress (mod 32) == count[4:0] at all times.
- empty and full are decoded from registered count. They are glitch-free and never both high.

## Timing
- Reset values: wraddress 0, rdaddress 0, count 0, empty 1, full 0, wren 0.
- Assertion of reset takes effect immediately, without waiting for a clock edge.
- Reset mid-operation discards all contents, all pending synchronizer state and any in-progress pulse.
- Request latency: let the raw input first be high at rising edge k.
  - s1 = 1 after edge k; s2 = 1 after edge k+1.
  - The pulse (and wren, if accepted) is high for exactly the one cycle between edges k+1 and k+2.
  - Pointer, count and flag updates are visible after edge k+2.
- RAM head data: ram32x4 registers rdaddress. q therefore shows the new head one cycle after rdaddress changes.
- A push into an empty FIFO clears empty after the accepting edge.

## Test plan
- Reset: assert reset asynchronously mid-cycle while count = 5 -> immediately count 0, empty 1, full 0, both pointers 0, wren 0.
- Single push: write held high for 20 cycles -> wren high for exactly 1 cycle, 2 cycles after the first sampling edge, with wraddress = 0; afterwards wraddress 1, count 1, empty 0; no second push until write is released and pressed again.
- Fill and overflow: 33 separate push presses from reset -> wraddress 0..31 on successive wren pulses; count 32, full 1, wraddress wrapped to 0; the 33rd press gives no wren and no state change.
- Drain and underflow: from full, 33 separate pop presses -> rdaddress advances 0..31 and wraps to 0; count reaches 0, empty 1; the 33rd press gives no change.
- Simultaneous requests:
  - count 3: read and write pulse in the same cycle -> both pointers +1, count stays 3, wren 1.
  - empty: same -> push only, count 1, rdaddress unchanged.
  - full: same -> pop only, count 31, wren 0.
- Wrap invariant: 100 random push/pop presses, including around pointer 31 -> 0 -> after every edge, (wraddress - rdaddress) mod 32 == count[4:0], and count stays within 0..32.
